// File: rtl/pc_fetch_ctrl_rv32i_if.sv
// rtl/pc_fetch_ctrl_rv32i_if.sv - instruction-memory and decode handshake bundle for the fetch sequencer
interface pc_fetch_ctrl_rv32i_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        instr_valid;
  logic [31:0] instr_out;
  logic [31:0] instr_pc;
  logic        instr_ready;

  // master: the fetch controller; slave: memory + decode side
  modport master (
    output imem_req, imem_addr,
    input  imem_ack, imem_rdata,
    output instr_valid, instr_out, instr_pc,
    input  instr_ready
  );

  modport slave (
    input  imem_req, imem_addr,
    output imem_ack, imem_rdata,
    input  instr_valid, instr_out, instr_pc,
    output instr_ready
  );
endinterface

// File: rtl/pc_fetch_ctrl_rv32i.sv
// rtl/pc_fetch_ctrl_rv32i.sv - RV32I fetch sequencer: PC ownership, imem requests, decode buffer
module pc_fetch_ctrl_rv32i #(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter logic [31:0] TRAP_VEC    = 32'h0000_0100,
  parameter int          ACK_TIMEOUT = 16
) (
  input  logic                         clk,
  input  logic                         rst,
  pc_fetch_ctrl_rv32i_if.master        bus,
  input  logic                         redirect_valid_i,
  input  logic [31:0]                  redirect_target_i,
  input  logic                         trap_i,
  output logic                         misalign_fault_o,
  output logic                         fetch_timeout_o
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_HOLD, S_FLUSH} state_t;

  localparam int CNT_W = (ACK_TIMEOUT > 2) ? $clog2(ACK_TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((ACK_TIMEOUT > 0) ? ACK_TIMEOUT - 1 : 0);
  localparam bit TO_EN = (ACK_TIMEOUT != 0);

  state_t           state_q, state_d;
  logic [31:0]      pc_q, pc_d;
  logic [31:0]      pend_q, pend_d;
  logic [31:0]      instr_out_q, instr_out_d;
  logic [31:0]      instr_pc_q, instr_pc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             misalign_q, misalign_d;
  logic             timeout_q, timeout_d;

  // Control-flow change decode: trap outranks redirect, a misaligned redirect becomes a trap vector
  logic        event_w;
  logic        misalign_w;
  logic [31:0] target_w;
  logic [31:0] pend_w;
  logic        cnt_hit_w;

  assign event_w    = trap_i | redirect_valid_i;
  assign misalign_w = redirect_valid_i & ~trap_i & (redirect_target_i[1:0] != 2'b00);
  assign target_w   = (trap_i | misalign_w) ? TRAP_VEC : redirect_target_i;
  // In FLUSH the most recent control-flow change replaces the pending target
  assign pend_w     = event_w ? target_w : pend_q;
  assign cnt_hit_w  = TO_EN && (cnt_q == CNT_LAST);

  // State and datapath registers, reset asynchronously
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      pc_q        <= RESET_PC;
      pend_q      <= '0;
      instr_out_q <= '0;
      instr_pc_q  <= '0;
      cnt_q       <= '0;
      misalign_q  <= 1'b0;
      timeout_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      pend_q      <= pend_d;
      instr_out_q <= instr_out_d;
      instr_pc_q  <= instr_pc_d;
      cnt_q       <= cnt_d;
      misalign_q  <= misalign_d;
      timeout_q   <= timeout_d;
    end
  end

  // Next-state, next-PC and pulse generation
  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    pend_d      = pend_q;
    instr_out_d = instr_out_q;
    instr_pc_d  = instr_pc_q;
    cnt_d       = cnt_q;
    misalign_d  = 1'b0;
    timeout_d   = 1'b0;

    case (state_q)
      S_IDLE: begin
        state_d = S_REQ;
        cnt_d   = '0;
      end

      S_REQ: begin
        misalign_d = misalign_w;
        if (bus.imem_ack) begin
          cnt_d = '0;
          if (event_w) begin
            // Returned word is on the wrong path; refetch from the new target
            pc_d = target_w;
          end else begin
            instr_out_d = bus.imem_rdata;
            instr_pc_d  = pc_q;
            pc_d        = pc_q + 32'd4;
            state_d     = S_HOLD;
          end
        end else if (event_w) begin
          // Address must stay stable until the memory acks, so park the target
          pend_d  = target_w;
          state_d = S_FLUSH;
          cnt_d   = '0;
        end else if (cnt_hit_w) begin
          timeout_d = 1'b1;
          pc_d      = TRAP_VEC;
          state_d   = S_IDLE;
          cnt_d     = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      S_HOLD: begin
        misalign_d = misalign_w;
        if (event_w) begin
          // Squash the buffered word; pc already advanced, so overwrite it
          pc_d    = target_w;
          state_d = S_REQ;
          cnt_d   = '0;
        end else if (bus.instr_ready) begin
          state_d = S_REQ;
          cnt_d   = '0;
        end
      end

      S_FLUSH: begin
        misalign_d = misalign_w;
        pend_d     = pend_w;
        if (bus.imem_ack) begin
          pc_d    = pend_w;
          state_d = S_REQ;
          cnt_d   = '0;
        end else if (cnt_hit_w) begin
          timeout_d = 1'b1;
          pc_d      = pend_w;
          state_d   = S_IDLE;
          cnt_d     = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign bus.imem_req    = (state_q == S_REQ) || (state_q == S_FLUSH);
  assign bus.imem_addr   = pc_q;
  assign bus.instr_valid = (state_q == S_HOLD);
  assign bus.instr_out   = instr_out_q;
  assign bus.instr_pc    = instr_pc_q;
  assign misalign_fault_o = misalign_q;
  assign fetch_timeout_o  = timeout_q;

endmodule

// File: tb/tb_pc_fetch_ctrl_rv32i.sv
// tb/tb_pc_fetch_ctrl_rv32i.sv - directed self-checking bench for pc_fetch_ctrl_rv32i
module tb_pc_fetch_ctrl_rv32i;

  logic        clk;
  logic        rst;
  logic        redirect_valid;
  logic [31:0] redirect_target;
  logic        trap;
  logic        misalign_fault;
  logic        fetch_timeout;

  int total;
  int bad;

  pc_fetch_ctrl_rv32i_if bus();

  pc_fetch_ctrl_rv32i #(
    .RESET_PC   (32'h0000_0000),
    .TRAP_VEC   (32'h0000_0100),
    .ACK_TIMEOUT(16)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .bus              (bus.master),
    .redirect_valid_i (redirect_valid),
    .redirect_target_i(redirect_target),
    .trap_i           (trap),
    .misalign_fault_o (misalign_fault),
    .fetch_timeout_o  (fetch_timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Ack the current REQ with a pattern word, then verify the buffered instruction in HOLD
  task automatic fetch(input logic [31:0] exp_addr, input logic rdy);
    chk("fetch_req", 32'(bus.imem_req), 32'd1);
    chk("fetch_addr", bus.imem_addr, exp_addr);
    bus.imem_ack    = 1'b1;
    bus.imem_rdata  = exp_addr ^ 32'hA5A5_0000;
    bus.instr_ready = rdy;
    step();
    bus.imem_ack    = 1'b0;
    bus.imem_rdata  = 32'h0;
    chk("hold_valid", 32'(bus.instr_valid), 32'd1);
    chk("hold_pc", bus.instr_pc, exp_addr);
    chk("hold_out", bus.instr_out, exp_addr ^ 32'hA5A5_0000);
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst             = 1'b1;
    redirect_valid  = 1'b0;
    redirect_target = 32'h0;
    trap            = 1'b0;
    bus.imem_ack    = 1'b0;
    bus.imem_rdata  = 32'h0;
    bus.instr_ready = 1'b0;

    @(negedge clk);
    @(negedge clk);
    chk("rst_req", 32'(bus.imem_req), 32'd0);
    chk("rst_valid", 32'(bus.instr_valid), 32'd0);
    chk("rst_out", bus.instr_out, 32'h0);
    chk("rst_ipc", bus.instr_pc, 32'h0);
    chk("rst_mis", 32'(misalign_fault), 32'd0);
    chk("rst_to", 32'(fetch_timeout), 32'd0);
    chk("rst_addr", bus.imem_addr, 32'h0);

    // 1: sequential fetch 0,4,8,12 with decode always ready
    rst = 1'b0;
    chk("idle_req", 32'(bus.imem_req), 32'd0);
    step();
    for (int i = 0; i < 4; i++) begin
      fetch(32'(i * 4), 1'b1);
      step();
    end

    // 2: decode stalls for 5 cycles, buffer must hold steady
    fetch(32'h10, 1'b0);
    for (int i = 0; i < 5; i++) begin
      step();
      chk("stall_valid", 32'(bus.instr_valid), 32'd1);
      chk("stall_out", bus.instr_out, 32'h10 ^ 32'hA5A5_0000);
      chk("stall_pc", bus.instr_pc, 32'h10);
      chk("stall_req", 32'(bus.imem_req), 32'd0);
    end
    bus.instr_ready = 1'b1;
    step();

    // 3: redirect to 0x200 while a fetch is outstanding, ack 3 cycles later
    chk("r3_addr0", bus.imem_addr, 32'h14);
    redirect_valid  = 1'b1;
    redirect_target = 32'h200;
    step();
    redirect_valid  = 1'b0;
    chk("r3_req1", 32'(bus.imem_req), 32'd1);
    chk("r3_addr1", bus.imem_addr, 32'h14);
    chk("r3_mis", 32'(misalign_fault), 32'd0);
    step();
    chk("r3_addr2", bus.imem_addr, 32'h14);
    step();
    chk("r3_addr3", bus.imem_addr, 32'h14);
    bus.imem_ack   = 1'b1;
    bus.imem_rdata = 32'hDEAD_BEEF;
    step();
    bus.imem_ack   = 1'b0;
    chk("r3_drop", 32'(bus.instr_valid), 32'd0);
    chk("r3_new", bus.imem_addr, 32'h200);
    fetch(32'h200, 1'b1);
    step();

    // 4: misaligned redirect goes to the trap vector with a one-cycle fault pulse
    chk("r4_addr0", bus.imem_addr, 32'h204);
    redirect_valid  = 1'b1;
    redirect_target = 32'h202;
    step();
    redirect_valid  = 1'b0;
    chk("r4_mis1", 32'(misalign_fault), 32'd1);
    chk("r4_addr1", bus.imem_addr, 32'h204);
    step();
    chk("r4_mis2", 32'(misalign_fault), 32'd0);
    bus.imem_ack = 1'b1;
    step();
    bus.imem_ack = 1'b0;
    chk("r4_vec", bus.imem_addr, 32'h100);
    chk("r4_drop", 32'(bus.instr_valid), 32'd0);
    fetch(32'h100, 1'b0);
    // trap together with a (misaligned) redirect while in HOLD: trap wins, no fault
    trap            = 1'b1;
    redirect_valid  = 1'b1;
    redirect_target = 32'h302;
    bus.instr_ready = 1'b1;
    step();
    trap            = 1'b0;
    redirect_valid  = 1'b0;
    chk("r4_squash", 32'(bus.instr_valid), 32'd0);
    chk("r4_trap", bus.imem_addr, 32'h100);
    chk("r4_trmis", 32'(misalign_fault), 32'd0);

    // 5: no ack for 16 cycles -> timeout pulse, one IDLE cycle, refetch at 0x100
    for (int i = 0; i < 15; i++) begin
      step();
      chk("t5_wait", 32'(fetch_timeout), 32'd0);
    end
    chk("t5_req16", 32'(bus.imem_req), 32'd1);
    step();
    chk("t5_pulse", 32'(fetch_timeout), 32'd1);
    chk("t5_idle", 32'(bus.imem_req), 32'd0);
    step();
    chk("t5_pulse_end", 32'(fetch_timeout), 32'd0);
    chk("t5_req", 32'(bus.imem_req), 32'd1);
    chk("t5_addr", bus.imem_addr, 32'h100);

    // 6: ack coincident with redirect -> refetch at the top of memory, then wrap to 0
    redirect_valid  = 1'b1;
    redirect_target = 32'hFFFF_FFFC;
    bus.imem_ack    = 1'b1;
    step();
    redirect_valid  = 1'b0;
    bus.imem_ack    = 1'b0;
    chk("w6_drop", 32'(bus.instr_valid), 32'd0);
    fetch(32'hFFFF_FFFC, 1'b1);
    step();
    chk("w6_wrap", bus.imem_addr, 32'h0);
    // reset in FLUSH abandons the request immediately
    redirect_valid  = 1'b1;
    redirect_target = 32'h400;
    step();
    redirect_valid  = 1'b0;
    chk("w6_flush_req", 32'(bus.imem_req), 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("w6_rst_req", 32'(bus.imem_req), 32'd0);
    chk("w6_rst_valid", 32'(bus.instr_valid), 32'd0);
    chk("w6_rst_ipc", bus.instr_pc, 32'h0);
    chk("w6_rst_addr", bus.imem_addr, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    step();
    chk("w6_restart", bus.imem_addr, 32'h0);
    fetch(32'h0, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
